// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// and the big-endian byte-enable helper (enable bit 3 is the most significant byte lane).
package dmem_pkg;

    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Offset 0 addresses the most significant lane; low offset bits are dropped for
    // halfword and word so the enables always cover an aligned region.
    function automatic logic [3:0] byte_en(input logic [1:0] dsize, input logic [1:0] off);
        logic [3:0] be;
        case (dsize)
            DSIZE_BYTE: be = 4'b1000 >> off;
            DSIZE_HALF: be = 4'b1100 >> {off[1], 1'b0};
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_write.sv
// Combinational store path: byte enables, replicated lane data and the merge into the old word.
// With DMEM_MISALIGN_TRAP_EN defined, misaligned halfword/word accesses flag err and write nothing.
module dmem_lane_write
    import dmem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       dsize,
    input  logic [1:0]       off,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] old_word,
    output logic [WIDTH-1:0] new_word,
    output logic             err
);

    localparam int LW = WIDTH / 4;

    logic             misaligned;
    logic [3:0]       be;
    logic [WIDTH-1:0] lane_data;
    logic [WIDTH-1:0] mask;

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        case (dsize)
            DSIZE_BYTE: misaligned = 1'b0;
            DSIZE_HALF: misaligned = off[0];
            default:    misaligned = |off;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Loads and trapped stores get no enables, so new_word is simply the old word.
    assign be = (we && !misaligned) ? byte_en(dsize, off) : 4'b0000;

    always_comb begin
        case (dsize)
            DSIZE_BYTE: lane_data = {4{wdata[LW-1:0]}};
            DSIZE_HALF: lane_data = {2{wdata[2*LW-1:0]}};
            default:    lane_data = wdata;
        endcase
    end

    assign mask     = {{LW{be[3]}}, {LW{be[2]}}, {LW{be[1]}}, {LW{be[0]}}};
    assign new_word = (old_word & ~mask) | (lane_data & mask);
    assign err      = misaligned;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels around a word store
// with a fixed access latency; misalignment trapping is enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             req_we,
    input  logic [1:0]       req_dsize,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit DIRECT = (LATENCY == 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds valid and payload stable until then, and ready never waits on valid.
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             we_q;
    logic [1:0]       dsize_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             commit;
    logic [WIDTH-1:0] acc_addr;
    logic [WIDTH-1:0] acc_wdata;
    logic             acc_we;
    logic [1:0]       acc_dsize;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] new_word;
    logic             err;
    logic             unused_addr_bits;

    assign accept = (state == ST_IDLE) && req_valid;

    // With single-cycle latency the access uses the live request on the accept edge.
    assign acc_addr  = DIRECT ? req_addr  : addr_q;
    assign acc_wdata = DIRECT ? req_wdata : wdata_q;
    assign acc_we    = DIRECT ? req_we    : we_q;
    assign acc_dsize = DIRECT ? req_dsize : dsize_q;
    assign commit    = DIRECT ? accept : ((state == ST_BUSY) && (cnt == '0));

    assign idx              = acc_addr[AW+1:2];
    assign old_word         = mem[idx];
    assign unused_addr_bits = ^acc_addr[WIDTH-1:AW+2];

    dmem_lane_write #(.WIDTH(WIDTH)) u_lane_write (
        .dsize    (acc_dsize),
        .off      (acc_addr[1:0]),
        .we       (acc_we),
        .wdata    (acc_wdata),
        .old_word (old_word),
        .new_word (new_word),
        .err      (err)
    );

    // Store contents survive reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (reset && commit && acc_we && !err) begin
            mem[idx] <= new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            dsize_q    <= DSIZE_BYTE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        we_q      <= req_we;
                        dsize_q   <= req_dsize;
                        cnt       <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        if (DIRECT) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= new_word;
                            resp_err   <= err;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= new_word;
                        resp_err   <= err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a vector table, hand-written hold/reset/misalignment sequences
// and a randomized phase checked against a big-endian word-store model through a queue.
module tb_dmem_responder;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_dsize = 2'b00;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic [31:0] exp_q[$];
    logic        err_q[$];
    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic        we;
        logic [1:0]  ds;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    dmem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .req_dsize  (req_dsize),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Model of the store: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] model_apply(input logic we, input logic [1:0] ds,
                                                input logic [31:0] addr, input logic [31:0] wd);
        int idx;
        int off;
        logic [31:0] w;
        idx = int'(addr[31:2]) % DEPTH;
        off = int'(addr[1:0]);
        w = mdl[idx];
        if (we) begin
            case (ds)
                2'b00:   w[31-8*off -: 8]  = wd[7:0];
                2'b01:   w[31-8*off -: 16] = wd[15:0];
                default: w = wd;
            endcase
        end
        mdl[idx] = w;
        return w;
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] ds,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_dsize = ds;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic clear_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_dsize = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // One full transaction; during 'hold' cycles a competing store to the same address is offered.
    task automatic txn(input logic we, input logic [1:0] ds, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp, input logic exp_err,
                       input int hold, input string name);
        int n;
        int acc;
        @(negedge clk);
        drive_req(we, ds, addr, wd);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            note_timeout({name, " accept"});
            clear_req();
            return;
        end
        acc = cycle + 1;
        exp_q.push_back(exp);
        err_q.push_back(exp_err);
        @(negedge clk);
        clear_req();
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            note_timeout({name, " response"});
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            return;
        end
        check({name, " latency"}, 32'(cycle - acc), 32'(LATENCY));
        for (int h = 0; h < hold; h++) begin
            drive_req(1'b1, 2'b10, addr, 32'hFFFF_FFFF);
            @(negedge clk);
            check({name, " hold valid"}, 32'(resp_valid), 32'd1);
            check({name, " hold rdata"}, resp_rdata, exp_q[0]);
            check({name, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        clear_req();
        resp_ready = 1'b1;
        check({name, " rdata"}, resp_rdata, exp_q.pop_front());
        check({name, " err"}, 32'(resp_err), 32'(err_q.pop_front()));
        @(negedge clk);
        resp_ready = 1'b0;
        check({name, " valid drop"}, 32'(resp_valid), 32'd0);
        check({name, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    // Accept a request, then pulse reset after wait_n more cycles; no response may follow.
    task automatic abort_txn(input logic we, input logic [1:0] ds, input logic [31:0] addr,
                             input logic [31:0] wd, input int wait_n, input string name);
        int n;
        @(negedge clk);
        drive_req(we, ds, addr, wd);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            note_timeout({name, " accept"});
            clear_req();
            return;
        end
        @(negedge clk);
        clear_req();
        repeat (wait_n) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check({name, " valid in reset"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        check({name, " ready after reset"}, 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, " no stray resp"}, 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 32'h10,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 32'h10,   32'h1122_3344, 32'h1122_3344, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 32'h11,   32'h0000_00AA, 32'h11AA_3344, 1'b0};
        vecs[4]  = '{1'b0, 2'b10, 32'h10,   32'h0,         32'h11AA_3344, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 32'h10,   32'h1122_3344, 32'h1122_3344, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 32'h12,   32'h0000_BEEF, 32'h1122_BEEF, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 32'h10,   32'h0,         32'h1122_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 32'h1010, 32'h0,         32'h1122_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 32'h13,   32'hFFFF_FF55, 32'h1122_BE55, 1'b0};
        vecs[10] = '{1'b1, 2'b01, 32'h10,   32'hABCD_1234, 32'h1234_BE55, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 32'h12,   32'h0,         32'h1234_BE55, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 32'h20,   32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 32'h20,   32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[14] = '{1'b1, 2'b11, 32'h24,   32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            txn(vecs[i].we, vecs[i].ds, vecs[i].addr, vecs[i].wd, vecs[i].exp, vecs[i].err,
                0, $sformatf("vec%0d", i));
        end

        // Stalled response with a competing store offered; the store must never land.
        txn(1'b0, 2'b10, 32'h10, 32'h0, 32'h1234_BE55, 1'b0, 5, "stall");
        txn(1'b0, 2'b10, 32'h10, 32'h0, 32'h1234_BE55, 1'b0, 0, "after stall");

        abort_txn(1'b1, 2'b10, 32'h20, 32'hFFFF_FFFF, 0, "reset busy");
        txn(1'b0, 2'b10, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0, 0, "after busy reset");
        abort_txn(1'b0, 2'b10, 32'h24, 32'h0, 2, "reset resp");
        txn(1'b0, 2'b10, 32'h24, 32'h0, 32'hA5A5_5A5A, 1'b0, 0, "after resp reset");

`ifdef DMEM_MISALIGN_TRAP_EN
        txn(1'b1, 2'b10, 32'h22, 32'hCAFE_F00D, 32'h0BAD_F00D, 1'b1, 0, "misaligned word");
        txn(1'b0, 2'b10, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0, 0, "misaligned check");
        txn(1'b1, 2'b01, 32'h25, 32'h0000_7777, 32'hA5A5_5A5A, 1'b1, 0, "misaligned half");
`else
        txn(1'b1, 2'b10, 32'h22, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0, "misaligned word");
        txn(1'b0, 2'b10, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 0, "misaligned check");
        txn(1'b1, 2'b01, 32'h25, 32'h0000_7777, 32'h7777_5A5A, 1'b0, 0, "misaligned half");
`endif

        for (int i = 64; i < 72; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] e;
            a = 32'(i * 4);
            d = $urandom;
            e = model_apply(1'b1, 2'b10, a, d);
            txn(1'b1, 2'b10, a, d, e, 1'b0, 0, "rand init");
        end
        for (int i = 0; i < 30; i++) begin
            logic        we;
            logic [1:0]  ds;
            logic [1:0]  off;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] e;
            we  = 1'($urandom_range(0, 1));
            ds  = 2'($urandom_range(0, 3));
            off = (ds == 2'b00) ? 2'($urandom_range(0, 3)) :
                  (ds == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            a   = {20'h0, 7'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), off} + 32'h100;
            a   = {a[31:12], 2'b00, 1'b1, 2'b00, a[6:0]} & 32'h0000_011F | {30'h0, off};
            d   = $urandom;
            e   = model_apply(we, ds, a, d);
            txn(we, ds, a, d, e, 1'b0, 0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
